// File: rtl/usb_pkg.sv
// Shared types and constants for the USB full-speed transmit path.
package usb_pkg;

    typedef enum logic [2:0] {
        TX_NONE  = 3'd0,
        TX_DATA0 = 3'd1,
        TX_DATA1 = 3'd2,
        TX_ACK   = 3'd3,
        TX_NAK   = 3'd4,
        TX_STALL = 3'd5
    } tx_packet_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_EOP
    } tx_state_t;

    typedef enum logic [1:0] {
        SYM_RAW,
        SYM_SE0,
        SYM_J
    } line_sym_t;

    localparam logic [7:0]  PID_DATA0  = 8'hC3;
    localparam logic [7:0]  PID_DATA1  = 8'h4B;
    localparam logic [7:0]  PID_ACK    = 8'hD2;
    localparam logic [7:0]  PID_NAK    = 8'h5A;
    localparam logic [7:0]  PID_STALL  = 8'h1E;
    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Line states as {dplus, dminus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    function automatic logic [7:0] pid_byte(input tx_packet_t p);
        case (p)
            TX_DATA0: return PID_DATA0;
            TX_DATA1: return PID_DATA1;
            TX_ACK:   return PID_ACK;
            TX_NAK:   return PID_NAK;
            TX_STALL: return PID_STALL;
            default:  return 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

    function automatic logic [1:0] nrzi_toggle(input logic [1:0] line);
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_tx_bit_encoder.sv
// Line-bit engine: bit-period down-counter, NRZI line register and bit stuffing.
// A symbol is consumed (take) only on a period boundary when no stuff bit is owed.
module usb_tx_bit_encoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      sym_valid,
    input  line_sym_t sym_kind,
    input  logic      sym_raw,
    output logic      take,
    output logic      bit_done,
    output logic      dplus,
    output logic      dminus
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] timer;
    logic [2:0]    ones;
    logic [1:0]    line;
    logic          busy;
    logic          boundary;
    logic          stuff;

    assign boundary        = (timer == '0);
    assign stuff           = boundary && (ones == 3'd6);
    assign take            = boundary && !stuff && sym_valid;
    assign bit_done        = boundary && busy;
    assign {dplus, dminus} = line;

    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
            ones  <= '0;
            line  <= LINE_J;
            busy  <= 1'b0;
        end else if (!boundary) begin
            timer <= timer - 1'b1;
        end else if (stuff) begin
            line  <= nrzi_toggle(line);
            ones  <= '0;
            timer <= LAST;
            busy  <= 1'b1;
        end else if (sym_valid) begin
            timer <= LAST;
            busy  <= 1'b1;
            case (sym_kind)
                SYM_RAW: begin
                    if (sym_raw) begin
                        ones <= ones + 1'b1;
                    end else begin
                        line <= nrzi_toggle(line);
                        ones <= '0;
                    end
                end
                SYM_SE0: begin
                    line <= LINE_SE0;
                    ones <= '0;
                end
                default: begin
                    line <= LINE_J;
                    ones <= '0;
                end
            endcase
        end else begin
            busy <= 1'b0;
        end
    end

endmodule

// File: rtl/usb_tx_packetizer.sv
// USB full-speed TX packetizer: SYNC, PID, payload, CRC16, EOP onto D+/D-.
// Optional statistics counters are built when USB_TX_STATS_EN is defined.
//   state   | meaning
//   IDLE    | line J; waiting for a command (or finishing the EOP J bit)
//   SYNC    | sending SYNC bits 1..7
//   PID     | sending the PID byte
//   DATA    | sending payload bytes, fetching the next one during bit 7
//   CRC     | sending ~crc, bit 15 first
//   EOP     | SE0, SE0, J
module usb_tx_packetizer
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 4,
    parameter int MAX_PKT_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  tx_packet,
    input  logic [6:0]  buffer_occupancy,
    input  logic [7:0]  tx_packet_data,
    output logic        get_tx_packet_data,
    output logic        dplus_out,
    output logic        dminus_out,
    output logic        tx_transfer_active,
`ifdef USB_TX_STATS_EN
    output logic [15:0] pkt_count,
    output logic [15:0] byte_count,
`endif
    output logic        tx_error
);

    localparam logic [6:0] MAX_BYTES = 7'(MAX_PKT_BYTES);

    tx_state_t  state, state_nxt;
    tx_packet_t pid_q;
    logic [3:0]  bit_idx;
    logic [6:0]  bytes_left;
    logic [7:0]  data_q;
    logic [7:0]  pid_bits;
    logic [15:0] crc;
    logic        active_q;
    logic        get_q;
    logic        error_q;
    logic        sym_valid;
    line_sym_t   sym_kind;
    logic        sym_raw;
    logic        take;
    logic        bit_done;
    logic        cmd_legal;
    logic        is_data;

    assign cmd_legal = (tx_packet >= 3'd1) && (tx_packet <= 3'd5);
    assign is_data   = (pid_q == TX_DATA0) || (pid_q == TX_DATA1);
    assign pid_bits  = pid_byte(pid_q);

    usb_tx_bit_encoder #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_enc (
        .clk      (clk),
        .rst      (rst),
        .sym_valid(sym_valid),
        .sym_kind (sym_kind),
        .sym_raw  (sym_raw),
        .take     (take),
        .bit_done (bit_done),
        .dplus    (dplus_out),
        .dminus   (dminus_out)
    );

    always_comb begin
        state_nxt = state;
        sym_valid = 1'b0;
        sym_kind  = SYM_RAW;
        sym_raw   = 1'b0;
        case (state)
            ST_IDLE: begin
                // active_q still high means the EOP J bit is on the line
                if (!active_q && cmd_legal) begin
                    sym_valid = 1'b1;
                    sym_raw   = SYNC_BYTE[0];
                    if (take) state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                sym_valid = 1'b1;
                sym_raw   = SYNC_BYTE[bit_idx[2:0]];
                if (take && bit_idx == 4'd7) state_nxt = ST_PID;
            end
            ST_PID: begin
                sym_valid = 1'b1;
                sym_raw   = pid_bits[bit_idx[2:0]];
                if (take && bit_idx == 4'd7) begin
                    if (!is_data)              state_nxt = ST_EOP;
                    else if (bytes_left != '0) state_nxt = ST_DATA;
                    else                       state_nxt = ST_CRC;
                end
            end
            ST_DATA: begin
                sym_valid = 1'b1;
                sym_raw   = (bit_idx == 4'd0) ? tx_packet_data[0] : data_q[bit_idx[2:0]];
                if (take && bit_idx == 4'd7 && bytes_left <= 7'd1) state_nxt = ST_CRC;
            end
            ST_CRC: begin
                sym_valid = 1'b1;
                sym_raw   = ~crc[4'd15 - bit_idx];
                if (take && bit_idx == 4'd15) state_nxt = ST_EOP;
            end
            ST_EOP: begin
                sym_valid = 1'b1;
                sym_kind  = (bit_idx < 4'd2) ? SYM_SE0 : SYM_J;
                if (take && bit_idx == 4'd2) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pid_q      <= TX_NONE;
            bit_idx    <= '0;
            bytes_left <= '0;
            data_q     <= '0;
            crc        <= CRC16_INIT;
            active_q   <= 1'b0;
            get_q      <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            get_q   <= 1'b0;
            error_q <= (state == ST_IDLE) && !active_q && (tx_packet >= 3'd6);
            if (take) begin
                if (state == ST_IDLE)
                    bit_idx <= 4'd1;
                else if (state_nxt != state || (state == ST_DATA && bit_idx == 4'd7))
                    bit_idx <= '0;
                else
                    bit_idx <= bit_idx + 1'b1;
            end
            if (state == ST_IDLE && take) begin
                pid_q      <= tx_packet_t'(tx_packet);
                bytes_left <= (buffer_occupancy > MAX_BYTES) ? MAX_BYTES : buffer_occupancy;
                crc        <= CRC16_INIT;
                active_q   <= 1'b1;
            end
            if (state == ST_PID && take && bit_idx == 4'd7 && is_data && bytes_left != '0)
                get_q <= 1'b1;
            if (state == ST_DATA && take) begin
                crc <= crc16_step(crc, sym_raw);
                if (bit_idx == 4'd0) data_q <= tx_packet_data;
                if (bit_idx == 4'd7) begin
                    bytes_left <= bytes_left - 1'b1;
                    if (bytes_left > 7'd1) get_q <= 1'b1;
                end
            end
            if (state == ST_IDLE && bit_done) active_q <= 1'b0;
        end
    end

    assign get_tx_packet_data = get_q;
    assign tx_transfer_active = active_q;
    assign tx_error           = error_q;

`ifdef USB_TX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count  <= '0;
            byte_count <= '0;
        end else begin
            if (state == ST_IDLE && bit_done) pkt_count <= pkt_count + 1'b1;
            if (state == ST_DATA && take && bit_idx == 4'd7) byte_count <= byte_count + 1'b1;
        end
    end
`else
    // statistics counters not built
`endif

endmodule

// File: doc/usb_tx_packetizer.md
Name: usb_tx_packetizer

Overview:
- USB full-speed transmit engine on the device side.
- Consumes the TX half of the data buffer, pulling bytes with get_tx_packet_data / tx_packet_data.
- Emits complete packets on D+/D−: SYNC, PID, payload, CRC16, EOP, with NRZI encoding and bit stuffing.
- Commanded by the protocol controller via tx_packet; sits between data_buffer and the USB pad drivers.

Parameters:
- CLKS_PER_BIT, 4, clk cycles per USB bit (48 MHz clk → 12 Mb/s); must be ≥2.
- MAX_PKT_BYTES, 64, payload cap; occupancy above this is clamped.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- tx_packet  in  3  command: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6/7 illegal
- buffer_occupancy  in  7  bytes available in the TX buffer; sampled at start
- tx_packet_data  in  8  buffer byte; valid from the cycle after a get pulse
- get_tx_packet_data  out  1  one-cycle byte request to the buffer
- dplus_out  out  1  D+ line
- dminus_out  out  1  D− line
- tx_transfer_active  out  1  high from the start cycle through the last EOP cycle
- tx_error  out  1  one-cycle pulse on an illegal command

Behaviour:
- Reset (rst high at posedge):
  - State → IDLE; dplus_out=1, dminus_out=0 (J).
  - get_tx_packet_data=0, tx_transfer_active=0, tx_error=0.
  - Bit timer, stuff counter and CRC are cleared.
  - Asserting rst mid-packet aborts at once: J on the next cycle, no EOP.
- Start:
  - In IDLE, tx_packet in 1..5 is latched at posedge N; tx_transfer_active=1 from N+1.
  - The first SYNC bit is driven from N+1.
  - For DATA packets, the byte count is latched as min(buffer_occupancy, MAX_PKT_BYTES).
  - tx_packet in 6/7 in IDLE: tx_error=1 for cycle N+1 only; stay IDLE.
  - tx_packet changes while busy are ignored.
- Bit timing:
  - Each line bit is held exactly CLKS_PER_BIT cycles.
  - All fields are sent LSB first, except CRC (see CRC).
- FSM: IDLE → SYNC (8 bits) → PID (8 bits).
  - From PID: DATA0/DATA1 → DATA if count>0, else → CRC; handshake PIDs → EOP.
  - DATA → CRC (16 bits) → EOP (3 bits) → IDLE.
- SYNC: raw bits 0,0,0,0,0,0,0,1, which produce line states KJKJKJKK.
- PID byte = {~pid[3:0], pid[3:0]}:
  - DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E.
- Byte fetch:
  - get_tx_packet_data pulses on the first cycle of the last bit period of the PID or the preceding data byte.
  - The next byte is captured at the byte boundary.
  - Exactly count pulses per DATA packet; none for handshakes or zero-length packets.
- NRZI:
  - Raw 0 toggles the line between J (1,0) and K (0,1); raw 1 holds it.
- Bit stuffing:
  - After six consecutive raw 1s, one stuffed 0 is inserted (line toggles) before the next raw bit.
  - The stuffed bit is excluded from the CRC and from field bit counts.
  - The run counter resets on any 0, stuffed or raw.
  - Stuffing applies from SYNC through the last CRC bit, never in EOP.
  - A stuff triggered by the final CRC bit is still sent before EOP.
- CRC:
  - Init 16'hFFFF, computed over the payload only, per raw bit b.
  - fb = b ^ crc[15]; crc = {crc[14:0],0} ^ (fb ? 16'h8005 : 0).
  - Transmitted as ~crc, bit 15 first.
  - Zero-length payload → CRC field bits all 0.
- EOP: two bit periods SE0 (0,0), then one bit period J.
  - tx_transfer_active falls in the cycle after the J bit ends.
  - The FSM can accept a new command in that same cycle.

Optional Feature:
- Macro USB_TX_STATS_EN.
- Defined:
  - Adds output pkt_count[15:0], incremented when EOP completes, wrapping at 16'hFFFF→0.
  - Adds output byte_count[15:0], incremented per payload byte sent.
  - Both counters are cleared by rst.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package usb_pkg holds:
  - tx_packet_t enum (NONE, DATA0, DATA1, ACK, NAK, STALL).
  - PID constants, SYNC_BYTE, CRC16_POLY=16'h8005, CRC16_INIT=16'hFFFF.
  - Line-state encodings J/K/SE0 and the FSM state enum.
- Sub-module usb_tx_bit_encoder holds the bit timer, NRZI register and stuff counter.
  - Inputs: raw bit plus a take/advance handshake.
  - Outputs: dplus/dminus and a bit_done strobe back to the FSM.

Test Plan:
- Reset with tx_packet=0 for 10 cycles → dplus=1, dminus=0, active=0, no get pulses.
- tx_packet=ACK → line KJKJKJKK, then PID 0xD2 bits, SE0,SE0,J; 76 active cycles; zero get pulses.
- DATA0 with occupancy=0 → raw bytes C3,00,00 then EOP; no get pulses; active = 35 bit periods.
- DATA1 with occupancy=2, bytes 0xFF,0xFF → exactly 2 get pulses; a stuffed bit after every 6th consecutive 1; CRC decoded at the receiver model leaves residual 0x800D.
- tx_packet=7 → single tx_error pulse; line stays J; active stays 0.
- rst asserted mid-payload of a 32-byte DATA0 → J on the next cycle, active=0; a new ACK command then transmits normally.
